agc_gain_ctrl: RTL and testbench

Closes the AGC loop opposite the peak-to-peak detector. On each `found` window strobe it compares the measured `Vpp` against a target window and steps an 8-bit gain code up or down with saturation. When the code changes, it writes the code to the analog gain element, a digital potentiometer with an MCP41xxx-style SPI write, as a 16-bit serial frame. Sits between the detector output and the PGA/pot pins.

---
 rtl/agc_gain_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_agc_gain_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_ctrl.sv
// agc_gain_ctrl
//
// Closes the AGC loop behind the peak-to-peak detector. Each detector window
// (rising edge of found) compares the latched Vpp with a target window and
// steps an 8-bit gain code up (slow release) or down (fast attack) with
// saturation. A changed code is written to an MCP41xxx-style digital pot as a
// 16-bit SPI mode-0 frame {8'h11, gain}, MSB first. After reset the current
// code is written once so the pot matches gain.
//
// Ports
//   clk_sample  in   single clock
//   rst         in   asynchronous active-low reset
//   Vpp         in   12-bit peak-to-peak value, valid while found is high
//   found       in   window-complete strobe (level, one window per rising edge)
//   gain        out  current gain code
//   busy        out  high while a frame is being sent (LOAD..END)
//   upd_done    out  one-cycle pulse in the cycle busy falls
//   overrun     out  one-cycle pulse when a window arrives outside IDLE
//   pga_cs_n    out  pot chip select, active low
//   pga_sclk    out  serial clock, idle low
//   pga_sdi     out  serial data, changes only at the start of an SCLK low phase
//   state_dbg   out  current FSM state encoding
//
// Handshake: found is a level strobe; only its rising edge (win) is a request.
// A request is accepted only in IDLE; anywhere else it is dropped and flagged
// on overrun. There is no back-pressure toward the detector.
module agc_gain_ctrl #(
  parameter int TARGET_HI = 2800,
  parameter int TARGET_LO = 2200,
  parameter int GAIN_MIN  = 0,
  parameter int GAIN_MAX  = 255,
  parameter int GAIN_INIT = 128,
  parameter int STEP_UP   = 1,
  parameter int STEP_DN   = 4,
  parameter int CLK_DIV   = 4
) (
  input  logic        clk_sample,
  input  logic        rst,
  input  logic [11:0] Vpp,
  input  logic        found,
  output logic [7:0]  gain,
  output logic        busy,
  output logic        upd_done,
  output logic        overrun,
  output logic        pga_cs_n,
  output logic        pga_sclk,
  output logic        pga_sdi,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_LOAD_PENDING = 3'd0,
    S_IDLE         = 3'd1,
    S_DECIDE       = 3'd2,
    S_LOAD         = 3'd3,
    S_SHIFT        = 3'd4,
    S_END          = 3'd5
  } state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
  localparam logic [11:0]   HI          = 12'(TARGET_HI);
  localparam logic [11:0]   LO          = 12'(TARGET_LO);
  localparam logic [8:0]    MIN_PLUS_DN = 9'(GAIN_MIN + STEP_DN);
  localparam logic [8:0]    GMAX9       = 9'(GAIN_MAX);
  localparam logic [8:0]    STEP_UP9    = 9'(STEP_UP);
  localparam logic [7:0]    STEP_DN8    = 8'(STEP_DN);
  localparam logic [7:0]    GMIN8       = 8'(GAIN_MIN);
  localparam logic [7:0]    GMAX8       = 8'(GAIN_MAX);
  localparam logic [7:0]    GINIT8      = 8'(GAIN_INIT);
  localparam logic [7:0]    POT_WRITE   = 8'h11;

  state_t          state_q, state_d;
  logic            found_d;
  logic [11:0]     vpp_q, vpp_d;
  logic [7:0]      gain_q, gain_d;
  logic            busy_q, busy_d;
  logic            upd_done_q, upd_done_d;
  logic            overrun_q, overrun_d;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic            sdi_q, sdi_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [CW-1:0]   div_cnt_q, div_cnt_d;

  logic            win;
  logic [8:0]      up_sum;
  logic [7:0]      gain_next;
  logic [15:0]     frame;

  assign win   = found & ~found_d;
  assign frame = {POT_WRITE, gain_q};

  // Gain step with 9-bit headroom so the saturation compares cannot wrap.
  always_comb begin
    up_sum    = {1'b0, gain_q} + STEP_UP9;
    gain_next = gain_q;
    if (vpp_q > HI) begin
      gain_next = ({1'b0, gain_q} < MIN_PLUS_DN) ? GMIN8 : (gain_q - STEP_DN8);
    end else if (vpp_q < LO) begin
      gain_next = (up_sum > GMAX9) ? GMAX8 : up_sum[7:0];
    end
  end

  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD_PENDING;
      found_d    <= 1'b0;
      vpp_q      <= '0;
      gain_q     <= GINIT8;
      busy_q     <= 1'b0;
      upd_done_q <= 1'b0;
      overrun_q  <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      sdi_q      <= 1'b0;
      bit_idx_q  <= '0;
      div_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      found_d    <= found;
      vpp_q      <= vpp_d;
      gain_q     <= gain_d;
      busy_q     <= busy_d;
      upd_done_q <= upd_done_d;
      overrun_q  <= overrun_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
      bit_idx_q  <= bit_idx_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vpp_d      = vpp_q;
    gain_d     = gain_q;
    busy_d     = busy_q;
    upd_done_d = 1'b0;
    overrun_d  = 1'b0;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    sdi_d      = sdi_q;
    bit_idx_d  = bit_idx_q;
    div_cnt_d  = div_cnt_q;

    // Windows outside IDLE are dropped; gain is left alone.
    if (win && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      // Power-on sync: send the reset code once so the pot matches gain.
      S_LOAD_PENDING: begin
        busy_d  = 1'b1;
        state_d = S_LOAD;
      end
      S_IDLE: begin
        if (win) begin
          vpp_d   = Vpp;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (gain_next != gain_q) begin
          gain_d  = gain_next;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cs_n_d    = 1'b0;
        sclk_d    = 1'b0;
        sdi_d     = frame[15];
        bit_idx_d = 4'd15;
        div_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      // Each bit: CLK_DIV cycles low then CLK_DIV cycles high. The next bit is
      // presented on the same edge that drops SCLK, so sdi is stable while high.
      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_idx_q == 4'd0) begin
              state_d = S_END;
            end else begin
              bit_idx_d = bit_idx_q - 4'd1;
              sdi_d     = frame[bit_idx_q - 4'd1];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_END: begin
        sclk_d     = 1'b0;
        cs_n_d     = 1'b1;
        busy_d     = 1'b0;
        upd_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gain      = gain_q;
  assign busy      = busy_q;
  assign upd_done  = upd_done_q;
  assign overrun   = overrun_q;
  assign pga_cs_n  = cs_n_q;
  assign pga_sclk  = sclk_q;
  assign pga_sdi   = sdi_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
module tb_agc_gain_ctrl;

  localparam int BUSY_LEN = 2 + 32 * 4;

  // ---------------- clock / reset ----------------
  logic        clk_sample = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] Vpp = '0;
  logic        found = 1'b0;
  logic [7:0]  gain;
  logic        busy;
  logic        upd_done;
  logic        overrun;
  logic        pga_cs_n;
  logic        pga_sclk;
  logic        pga_sdi;
  logic [2:0]  state_dbg;

  always #5 clk_sample = ~clk_sample;

  agc_gain_ctrl dut (
    .clk_sample(clk_sample),
    .rst(rst),
    .Vpp(Vpp),
    .found(found),
    .gain(gain),
    .busy(busy),
    .upd_done(upd_done),
    .overrun(overrun),
    .pga_cs_n(pga_cs_n),
    .pga_sclk(pga_sclk),
    .pga_sdi(pga_sdi),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  cur_gain = 8'd128;
  int          ov_cnt = 0;
  int          frame_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [15:0] cap_val = '0;
  int          cap_bits = 0;
  int          busy_cnt = 0;
  logic        sclk_prev = 1'b0;
  logic        cs_prev = 1'b1;
  logic        busy_prev = 1'b0;
  logic [15:0] exp_frame;

  always @(negedge clk_sample) begin
    if (!rst) begin
      cap_val   = '0;
      cap_bits  = 0;
      busy_cnt  = 0;
      sclk_prev = 1'b0;
      cs_prev   = 1'b1;
      busy_prev = 1'b0;
    end else begin
      if (pga_sclk && !sclk_prev && !pga_cs_n) begin
        cap_val  = {cap_val[14:0], pga_sdi};
        cap_bits = cap_bits + 1;
      end else if (pga_sclk && sclk_prev) begin
        check("sdi_stable_high", pga_sdi, cap_val[0]);
      end
      if (pga_cs_n && !cs_prev) begin
        frame_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", cap_val, 0);
          if (cap_val == 16'h0000) check("unexpected_frame_seen", 1, 0);
        end else begin
          exp_frame = exp_q.pop_front();
          check("frame_value", cap_val, exp_frame);
          check("frame_bits", cap_bits, 16);
        end
        cap_bits = 0;
        cap_val  = '0;
      end
      if (overrun) ov_cnt++;
      if (busy) busy_cnt++;
      if (!busy && busy_prev) begin
        check("busy_len", busy_cnt, BUSY_LEN);
        check("upd_done_at_busy_fall", upd_done, 1);
        busy_cnt = 0;
      end else if (upd_done) begin
        check("stray_upd_done", upd_done, 0);
      end
      sclk_prev = pga_sclk;
      cs_prev   = pga_cs_n;
      busy_prev = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sample);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) check("busy_timeout", busy, 0);
    repeat (3) @(posedge clk_sample);
  endtask

  // Async reset, then release and let the power-on frame go out.
  task automatic reset_dut();
    @(posedge clk_sample);
    #3 rst = 1'b0;
    #1;
    check("rst_gain", gain, 128);
    check("rst_busy", busy, 0);
    check("rst_cs_n", pga_cs_n, 1);
    check("rst_sclk", pga_sclk, 0);
    check("rst_sdi", pga_sdi, 0);
    check("rst_upd_done", upd_done, 0);
    check("rst_overrun", overrun, 0);
    exp_q.delete();
    exp_q.push_back(16'h1180);
    repeat (2) @(posedge clk_sample);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk_sample);
    #1;
    check("poweron_busy", busy, 1);
    wait_idle();
    check("poweron_gain", gain, 128);
    cur_gain = 8'd128;
  endtask

  // One-cycle found pulse; exp_gain is the hand-computed resulting code.
  task automatic do_window(input logic [11:0] v, input logic [7:0] exp_gain);
    logic chg;
    chg = (exp_gain != cur_gain);
    @(posedge clk_sample);
    #1 Vpp = v; found = 1'b1;
    @(posedge clk_sample);
    #1 found = 1'b0;
    check("gain_before_decide", gain, cur_gain);
    if (chg) exp_q.push_back({8'h11, exp_gain});
    @(posedge clk_sample);
    #1;
    check("gain_update", gain, exp_gain);
    check("busy_rise", busy, chg);
    @(posedge clk_sample);
    #1;
    check("cs_n_after_decide", pga_cs_n, !chg);
    wait_idle();
    check("gain_settled", gain, exp_gain);
    cur_gain = exp_gain;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ov_before;
    int fr_before;

    reset_dut();

    // Fast attack then slow release.
    do_window(12'd3000, 8'd124);
    do_window(12'd1000, 8'd125);

    // In-window and exactly-on-threshold values hold the code.
    do_window(12'd2500, 8'd125);
    do_window(12'd2800, 8'd125);
    do_window(12'd2200, 8'd125);

    // Window arriving mid-frame is dropped.
    ov_before = ov_cnt;
    @(posedge clk_sample);
    #1 Vpp = 12'd1000; found = 1'b1;
    @(posedge clk_sample);
    #1 found = 1'b0;
    exp_q.push_back(16'h117E);
    repeat (41) @(posedge clk_sample);
    #1 Vpp = 12'd3000; found = 1'b1;
    @(posedge clk_sample);
    #1 found = 1'b0;
    check("overrun_pulse", overrun, 1);
    @(posedge clk_sample);
    #1;
    check("overrun_one_cycle", overrun, 0);
    check("busy_during_overrun", busy, 1);
    wait_idle();
    check("gain_after_overrun", gain, 126);
    check("overrun_count", ov_cnt - ov_before, 1);
    cur_gain = 8'd126;

    // found held for 10 cycles: exactly one decision.
    ov_before = ov_cnt;
    fr_before = frame_cnt;
    exp_q.push_back(16'h117F);
    @(posedge clk_sample);
    #1 Vpp = 12'd1000; found = 1'b1;
    repeat (10) @(posedge clk_sample);
    #1 found = 1'b0;
    wait_idle();
    repeat (20) @(posedge clk_sample);
    check("held_found_gain", gain, 127);
    check("held_found_frames", frame_cnt - fr_before, 1);
    check("held_found_no_overrun", ov_cnt - ov_before, 0);
    cur_gain = 8'd127;

    // Reset mid-SHIFT.
    @(posedge clk_sample);
    #1 Vpp = 12'd3000; found = 1'b1;
    @(posedge clk_sample);
    #1 found = 1'b0;
    exp_q.push_back(16'h117B);
    repeat (22) @(posedge clk_sample);
    #1;
    check("mid_frame_cs_low", pga_cs_n, 0);
    reset_dut();

    // Climb to 254, then saturate at 255.
    for (int k = 0; k < 126; k++) begin
      do_window(12'd1000, 8'(129 + k));
    end
    do_window(12'd0, 8'd255);
    do_window(12'd0, 8'd255);

    // Back to 128, walk down to 4, up to 6, down to 2, then floor at 0.
    reset_dut();
    for (int k = 1; k <= 31; k++) begin
      do_window(12'd3000, 8'(128 - 4 * k));
    end
    do_window(12'd1000, 8'd5);
    do_window(12'd1000, 8'd6);
    do_window(12'd3000, 8'd2);
    do_window(12'd4095, 8'd0);
    do_window(12'd4095, 8'd0);

    repeat (10) @(posedge clk_sample);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
